// File: rtl/seq_shifter_pkg.sv
// Shared mode and state definitions for the iterative multi-mode shifter.
package seq_shifter_pkg;

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_ASR  = 3'b001;
  localparam logic [2:0] MODE_LSR  = 3'b010;
  localparam logic [2:0] MODE_LSL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // 110 and 111 fall into the LOAD class along with 000.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_ASR) && (m <= MODE_ROL);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-bit step: shifts or rotates the operand by one position.
module shift_step_unit
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_word,
  output logic             leaving_bit
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_word   = operand;
    leaving_bit = 1'b0;
    case (mode)
      MODE_ASR: begin
        next_word   = {operand[WIDTH-1], operand[WIDTH-1:1]};
        leaving_bit = operand[0];
      end
      MODE_LSR: begin
        next_word   = {1'b0, operand[WIDTH-1:1]};
        leaving_bit = operand[0];
      end
      MODE_LSL: begin
        next_word   = {operand[WIDTH-2:0], 1'b0};
        leaving_bit = operand[WIDTH-1];
      end
      MODE_ROR: begin
        next_word   = {operand[0], operand[WIDTH-1:1]};
        leaving_bit = operand[0];
      end
      MODE_ROL: begin
        next_word   = {operand[WIDTH-2:0], operand[WIDTH-1]};
        leaving_bit = operand[WIDTH-1];
      end
      default: begin
        next_word   = operand;
        leaving_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Iterative shifter: one bit per clock under a start/busy/done handshake.
module seq_barrel_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] count, count_d;
  logic [WIDTH-1:0] dout_d;
  logic             carry_d;
  logic             done_d;

  logic [WIDTH-1:0] step_word;
  logic             step_bit;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode        (mode_q),
    .operand     (dout),
    .next_word   (step_word),
    .leaving_bit (step_bit)
  );

  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    count_d = count;
    dout_d  = dout;
    carry_d = carry_out;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dout_d  = din;
          carry_d = 1'b0;
          if (!is_shift_mode(mode) || (amount == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            mode_d  = mode;
            count_d = amount;
          end
        end
      end
      ST_SHIFT: begin
        dout_d  = step_word;
        carry_d = step_bit;
        count_d = count - AMT_W'(1);
        if (count == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_LOAD;
      count     <= '0;
      dout      <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      mode_q    <= mode_d;
      count     <= count_d;
      dout      <= dout_d;
      carry_out <= carry_d;
      done      <= done_d;
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Self-checking bench: directed cases plus random operations against a closed-form shift model.
module tb_seq_barrel_shifter;

  localparam int W = 16;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   mode;
  logic [A-1:0] amount;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         carry_out;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] last_dout;

  seq_barrel_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .amount    (amount),
    .din       (din),
    .dout      (dout),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit shifts(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd5);
  endfunction

  // Whole-operation result {carry, word} from shift arithmetic, not step-by-step.
  function automatic logic [W:0] model(input logic [2:0] m, input int n, input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         c;
    int           k;
    r = x;
    c = 1'b0;
    if (!shifts(m) || n == 0) return {1'b0, x};
    k = n % W;
    case (m)
      3'd1: begin
        r = W'($signed(x) >>> n);
        c = x[(n - 1 < W - 1) ? n - 1 : W - 1];
      end
      3'd2: begin
        r = x >> n;
        c = (n <= W) ? x[n-1] : 1'b0;
      end
      3'd3: begin
        r = x << n;
        c = (n <= W) ? x[W-n] : 1'b0;
      end
      3'd4: begin
        r = (x >> k) | (x << (W - k));
        c = x[(n - 1) % W];
      end
      default: begin
        r = (x << k) | (x >> (W - k));
        c = x[W - 1 - ((n - 1) % W)];
      end
    endcase
    return {c, r};
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_op(input string tag, input logic [2:0] m, input int n,
                        input logic [W-1:0] x, input bit poke);
    logic [W:0] e;
    int busy_cycles;
    int waited;
    e = model(m, n, x);
    start = 1'b1; mode = m; amount = A'(n); din = x;
    @(negedge clk);
    start = 1'b0; din = W'($urandom); mode = 3'($urandom); amount = A'($urandom);
    busy_cycles = 0;
    waited = 0;
    while (!done && waited < 64) begin
      if (busy) busy_cycles++;
      waited++;
      start = poke && busy;
      if (poke && busy) din = 16'hFFFF;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_busy_cycles"}, busy_cycles, (shifts(m) && n > 0) ? n : 0);
    check({tag, "_dout"}, 32'(dout), 32'(e[W-1:0]));
    check({tag, "_carry"}, 32'(carry_out), 32'(e[W]));
    last_dout = e[W-1:0];
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(dout), 32'(last_dout));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'd0; amount = '0; din = '0;
    #3;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op("asr", 3'd1, 2, 16'h8004, 1'b0);
    idle_check("asr");

    // LSR with intermediate values observed step by step
    start = 1'b1; mode = 3'd2; amount = 5'd3; din = 16'h8004;
    @(negedge clk); start = 1'b0;
    check("lsr_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("lsr_step1", 32'(dout), 32'h4002);
    @(negedge clk);
    check("lsr_step2", 32'(dout), 32'h2001);
    @(negedge clk);
    check("lsr_final", 32'(dout), 32'h1000);
    check("lsr_carry", 32'(carry_out), 32'd1);
    check("lsr_done", 32'(done), 32'd1);
    last_dout = 16'h1000;
    idle_check("lsr");

    run_op("rol20", 3'd5, 20, 16'h8001, 1'b0);
    check("rol20_value", 32'(dout), 32'h0018);
    idle_check("rol20");
    run_op("lsl31", 3'd3, 31, 16'h00FF, 1'b0);
    idle_check("lsl31");
    run_op("load", 3'd0, 9, 16'h1234, 1'b0);
    idle_check("load");
    run_op("lsr0", 3'd2, 0, 16'h1234, 1'b0);
    idle_check("lsr0");
    run_op("mode7", 3'd7, 5, 16'hBEEF, 1'b0);
    idle_check("mode7");

    // start pulses while busy are ignored; next op starts in the done cycle
    run_op("asr_poke", 3'd1, 2, 16'h8004, 1'b1);
    run_op("b2b_ror", 3'd4, 5, 16'h0013, 1'b0);
    idle_check("b2b_ror");

    // Reset before step 3 of an LSL by 8
    start = 1'b1; mode = 3'd3; amount = 5'd8; din = 16'h0F0F;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_carry", 32'(carry_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] m;
      int n;
      logic [W-1:0] x;
      m = 3'($urandom_range(0, 7));
      n = $urandom_range(0, 31);
      x = W'($urandom);
      run_op("rand", m, n, x, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
